eq_4: RTL and testbench

Two-operand 4-bit equality checker for a switch/push-button front panel. Operator sets a 4-bit value on `no` and presses `push1` to capture operand A, then sets a value and presses `push2` to capture operand B. `ledpin` lights when both operands have been captured and are equal. Sits directly behind board I/O (switches, buttons, LED) in the top-level panel design.

---
 rtl/eq_4_pkg.sv | 12 +
 rtl/eq_4_debounce.sv | 45 ++++
 rtl/eq_4.sv | 83 ++++++++
 tb/tb_eq_4.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/eq_4_pkg.sv
// Shared types and defaults for the eq_4 front-panel equality checker.
//   OPERAND_W           : width of each captured operand
//   operand_t           : operand value type
//   DEBOUNCE_CYCLES_DEF : default stable-sample count for the button filter
package eq_4_pkg;

  localparam int unsigned OPERAND_W           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [OPERAND_W-1:0] operand_t;

endpackage

// File: rtl/eq_4_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a saturating-count filter.
// The filtered level only changes after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current level.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw, possibly asynchronous button level
//   level : filtered, registered button level
import eq_4_pkg::*;

module eq_4_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level once it has been seen DEBOUNCE_CYCLES times in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/eq_4.sv
// Two-operand 4-bit equality checker for a switch/push-button panel.
// push1 captures operand A from no, push2 captures operand B; ledpin lights one
// cycle after both operands have been captured and are equal.
// Optional button conditioning is enabled by defining EQ4_DEBOUNCE_EN.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   no     : operand value from switches
//   push1  : capture-A button, active-high
//   push2  : capture-B button, active-high
//   ledpin : registered equality indicator
import eq_4_pkg::*;

module eq_4 #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] no,
  input  logic                 push1,
  input  logic                 push2,
  output logic                 ledpin
);

  operand_t reg_a;
  operand_t reg_b;
  logic     valid_a;
  logic     valid_b;
  logic     push1_eff;
  logic     push2_eff;

  // A zero-cycle filter is meaningless; reject it at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("eq_4: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef EQ4_DEBOUNCE_EN
  eq_4_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_push1 (
    .clk   (clk),
    .rst   (rst),
    .btn   (push1),
    .level (push1_eff)
  );

  eq_4_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_push2 (
    .clk   (clk),
    .rst   (rst),
    .btn   (push2),
    .level (push2_eff)
  );
`else
  // Buttons are assumed synchronous to clk in this build.
  assign push1_eff = push1;
  assign push2_eff = push2;
`endif

  // Operand capture and compare; ledpin uses the pre-edge register values,
  // giving one cycle from load to LED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a   <= '0;
      reg_b   <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      ledpin  <= 1'b0;
    end else begin
      if (push1_eff) begin
        reg_a   <= no;
        valid_a <= 1'b1;
      end
      if (push2_eff) begin
        reg_b   <= no;
        valid_b <= 1'b1;
      end
      ledpin <= valid_a & valid_b & (reg_a == reg_b);
    end
  end

endmodule

// File: tb/tb_eq_4.sv
// Self-checking bench for eq_4 (default build, no button filter).
module tb_eq_4;

  logic       clk;
  logic       rst;
  logic [3:0] no;
  logic       push1;
  logic       push2;
  logic       ledpin;

  int errors = 0;
  int checks = 0;

  // Reference model state: operands, capture flags, expected LED.
  int  m_a, m_b;
  bit  m_va, m_vb;
  bit  m_led;

  typedef struct {
    logic       rst;
    logic [3:0] no;
    logic       p1;
    logic       p2;
    logic       exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  eq_4 dut (
    .clk    (clk),
    .rst    (rst),
    .no     (no),
    .push1  (push1),
    .push2  (push2),
    .ledpin (ledpin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: ledpin=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // The LED after an edge shows the compare of what was held before that edge.
  task automatic model_edge(input bit r, input int v, input bit p1, input bit p2);
    if (r) begin
      m_a = 0; m_b = 0; m_va = 0; m_vb = 0; m_led = 0;
    end else begin
      m_led = m_va && m_vb && (m_a == m_b);
      if (p1) begin m_a = v; m_va = 1; end
      if (p2) begin m_b = v; m_vb = 1; end
    end
  endtask

  // Drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic r, input logic [3:0] v, input logic p1, input logic p2);
    @(negedge clk);
    rst = r; no = v; push1 = p1; push2 = p2;
    @(posedge clk);
    #1;
    model_edge(r, int'(v), p1, p2);
  endtask

  initial begin
    // row: rst, no, push1, push2, ledpin expected after this edge
    vecs[0]  = '{1'b1, 4'h0,    1'b0, 1'b0, 1'b0};   // reset held across an edge
    vecs[1]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0};   // capture A
    vecs[2]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0};   // capture B (B not yet valid pre-edge)
    vecs[3]  = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b1};   // match shows one cycle later
    vecs[4]  = '{1'b0, 4'h5,    1'b0, 1'b0, 1'b1};   // held
    vecs[5]  = '{1'b0, 4'b1011, 1'b1, 1'b0, 1'b1};   // A<=1011, pre-edge still equal
    vecs[6]  = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b0};   // 1011 vs 1010
    vecs[7]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0};   // recapture A=1010
    vecs[8]  = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b1};   // equal again
    vecs[9]  = '{1'b0, 4'b1011, 1'b1, 1'b0, 1'b1};   // alternate: A<=1011
    vecs[10] = '{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0};   // B<=1010 ; pre 1011/1010
    vecs[11] = '{1'b0, 4'b1011, 1'b0, 1'b1, 1'b0};   // B<=1011 ; pre 1011/1010
    vecs[12] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1};   // A<=1010 ; pre 1011/1011
    vecs[13] = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b0};   // pre 1010/1011
    vecs[14] = '{1'b1, 4'h0,    1'b0, 1'b0, 1'b0};   // reset
    vecs[15] = '{1'b0, 4'h0,    1'b1, 1'b0, 1'b0};   // only A=0
    vecs[16] = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b0};   // B invalid though reg_b=0
    vecs[17] = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b0111, 1'b1, 1'b1, 1'b0};   // simultaneous load
    vecs[19] = '{1'b0, 4'h0,    1'b0, 1'b0, 1'b1};   // both 0111

    rst = 1'b1; no = 4'h0; push1 = 1'b0; push2 = 1'b0;
    #1;
    check("reset_initial", ledpin, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].no, vecs[i].p1, vecs[i].p2);
      check($sformatf("vec%0d", i), ledpin, vecs[i].exp);
    end

    // Reset asserted mid-clock with pushes active clears ledpin at once.
    @(negedge clk);
    #2;
    no = 4'b0111; push1 = 1'b1; push2 = 1'b1;
    rst = 1'b1;
    #1;
    check("reset_async", ledpin, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", ledpin, 1'b0);
    model_edge(1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0111, 1'b0, 1'b0);
      check($sformatf("post_reset%0d", i), ledpin, 1'b0);
    end

    // Held button tracks no while held.
    step(1'b0, 4'h3, 1'b1, 1'b1);
    step(1'b0, 4'h9, 1'b1, 1'b0);
    check("held_pre", ledpin, 1'b1);
    step(1'b0, 4'h3, 1'b1, 1'b0);
    check("held_mismatch", ledpin, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("held_track", ledpin, 1'b1);

    // Randomized traffic against the model; small value range makes matches common.
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      logic       p1, p2, r;
      v  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      p1 = ($urandom_range(0, 3) == 0);
      p2 = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, v, p1, p2);
      check($sformatf("rand%0d", i), ledpin, m_led);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
